// File: rtl/seq_pkg.sv
// Shared FSM state encoding and default geometry for the serial sequence generator.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LEN_W = 4;

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable MSB-first parallel-in/serial-out register; dout is the current MSB.
// Load wins over shift; zeros are shifted in at the bottom.
module seq_shift_reg
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign dout = sr[WIDTH-1];

endmodule

// File: rtl/sequence_generator.sv
// Serialises a captured pattern MSB-first, repeated repeats+1 times with idle gaps between frames.
// First bit appears the cycle after the accepting edge; start is only taken while ready (IDLE).
module sequence_generator
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  input  logic [3:0]       repeats,
  input  logic [3:0]       gap,
  output logic             ready,
  output logic             sequence_out,
  output logic             out_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    len_clamp;
  logic [CW-1:0]    len_q;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       frm_cnt;
  logic [3:0]       gap_q;
  logic [3:0]       gap_cnt;
  logic [WIDTH-1:0] din_aligned;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] sr_din;
  logic             sr_load;
  logic             sr_shift;
  logic             sr_dout;

  always_comb begin
    if (length == '0 || 32'(length) > WIDTH) begin
      len_clamp = CW'(WIDTH);
    end else begin
      len_clamp = CW'(length);
    end
  end

  // Left-justify the frame so its first bit sits at the register MSB.
  assign din_aligned = pattern << (CW'(WIDTH) - len_clamp);

  always_comb begin
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_din   = pat_q;
    if (reset) begin
      case (state)
        IDLE: begin
          if (start) begin
            sr_load = 1'b1;
            sr_din  = din_aligned;
          end
        end
        SHIFT: begin
          if (bit_cnt != '0) begin
            sr_shift = 1'b1;
          end else if (frm_cnt != 4'd0 && gap_q == 4'd0) begin
            sr_load = 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == 4'd1) begin
            sr_load = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  seq_shift_reg #(.WIDTH(WIDTH)) u_shift_reg (
    .clock (clock),
    .reset (reset),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .dout  (sr_dout)
  );

  // bit_cnt holds the number of bits still to follow the one currently on the wire.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      len_q   <= '0;
      bit_cnt <= '0;
      frm_cnt <= 4'd0;
      gap_q   <= 4'd0;
      gap_cnt <= 4'd0;
      pat_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pat_q   <= din_aligned;
            len_q   <= len_clamp;
            bit_cnt <= len_clamp - 1'b1;
            frm_cnt <= repeats;
            gap_q   <= gap;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else if (frm_cnt != 4'd0) begin
            frm_cnt <= frm_cnt - 4'd1;
            if (gap_q != 4'd0) begin
              gap_cnt <= gap_q;
              state   <= GAP;
            end else begin
              bit_cnt <= len_q - 1'b1;
            end
          end else begin
            state <= DONE;
          end
        end
        GAP: begin
          if (gap_cnt == 4'd1) begin
            bit_cnt <= len_q - 1'b1;
            state   <= SHIFT;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ready        = (state == IDLE);
  assign out_valid    = (state == SHIFT);
  assign sequence_out = (state == SHIFT) && sr_dout;
  assign done         = (state == DONE);

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator; each cycle checks {ready, out_valid, sequence_out, done}.
module tb_sequence_generator;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] length;
  logic [3:0] repeats;
  logic [3:0] gap;
  logic       ready;
  logic       sequence_out;
  logic       out_valid;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  sequence_generator dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .pattern      (pattern),
    .length       (length),
    .repeats      (repeats),
    .gap          (gap),
    .ready        (ready),
    .sequence_out (sequence_out),
    .out_valid    (out_valid),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got rdy/vld/dat/done=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] obs();
    return {ready, out_valid, sequence_out, done};
  endfunction

  // Nibble 0 of the stream is the most significant used nibble of v.
  task automatic expect_stream(input string tag, input logic [95:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d]", tag, i), obs(), v[4*(n-1-i) +: 4]);
      tick();
    end
  endtask

  task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r, input logic [3:0] g);
    pattern = p;
    length  = l;
    repeats = r;
    gap     = g;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    pattern = 8'h00;
    length  = 4'd0;
    repeats = 4'd0;
    gap     = 4'd0;
    tick();
    tick();
    check("reset_state", obs(), 4'b1000);
    reset = 1'b1;
    tick();
    check("idle_after_reset", obs(), 4'b1000);

    // 3-bit frame 101, single frame
    send(8'b0000_0101, 4'd3, 4'd0, 4'd0);
    expect_stream("f101", {4'b0110, 4'b0100, 4'b0110, 4'b0001, 4'b1000}, 5);

    // 3 frames of 110 separated by 2 idle cycles
    send(8'b0000_0110, 4'd3, 4'd2, 4'd2);
    expect_stream("rep_gap", {4'b0110, 4'b0110, 4'b0100, 4'b0000, 4'b0000,
                              4'b0110, 4'b0110, 4'b0100, 4'b0000, 4'b0000,
                              4'b0110, 4'b0110, 4'b0100, 4'b0001, 4'b1000}, 15);

    // length 0 and length 12 both mean the full 8 bits
    send(8'hA5, 4'd0, 4'd0, 4'd0);
    expect_stream("len0", {4'b0110, 4'b0100, 4'b0110, 4'b0100, 4'b0100,
                           4'b0110, 4'b0100, 4'b0110, 4'b0001, 4'b1000}, 10);
    send(8'hA5, 4'd12, 4'd0, 4'd0);
    expect_stream("len12", {4'b0110, 4'b0100, 4'b0110, 4'b0100, 4'b0100,
                            4'b0110, 4'b0100, 4'b0110, 4'b0001, 4'b1000}, 10);

    // start re-pulsed and inputs changed mid-frame
    send(8'hA5, 4'd8, 4'd0, 4'd0);
    expect_stream("mid_a", {4'b0110}, 1);
    start   = 1'b1;
    pattern = 8'hFF;
    length  = 4'd2;
    repeats = 4'd3;
    gap     = 4'd1;
    expect_stream("mid_b", {4'b0100, 4'b0110, 4'b0100, 4'b0100}, 4);
    start   = 1'b0;
    pattern = 8'h00;
    expect_stream("mid_c", {4'b0110, 4'b0100, 4'b0110, 4'b0001, 4'b1000, 4'b1000}, 6);

    // start held through DONE is taken only at the following IDLE edge
    pattern = 8'b0000_0101;
    length  = 4'd3;
    repeats = 4'd0;
    gap     = 4'd0;
    start   = 1'b1;
    tick();
    expect_stream("hold_a", {4'b0110, 4'b0100, 4'b0110, 4'b0001, 4'b1000}, 5);
    start = 1'b0;
    expect_stream("hold_b", {4'b0110, 4'b0100, 4'b0110, 4'b0001, 4'b1000}, 5);

    // reset during bit 2, with a coincident start that must be ignored
    send(8'hA5, 4'd8, 4'd0, 4'd0);
    expect_stream("rst_pre", {4'b0110, 4'b0100}, 2);
    reset = 1'b0;
    start = 1'b1;
    tick();
    check("rst_outputs", obs(), 4'b1000);
    reset = 1'b0;
    start = 1'b0;
    reset = 1'b1;
    tick();
    check("rst_still_idle", obs(), 4'b1000);
    send(8'h3C, 4'd8, 4'd0, 4'd0);
    expect_stream("rst_post", {4'b0100, 4'b0100, 4'b0110, 4'b0110, 4'b0110,
                               4'b0110, 4'b0100, 4'b0100, 4'b0001, 4'b1000}, 10);

    // back-to-back repeat with no gap
    send(8'b0000_0011, 4'd2, 4'd1, 4'd0);
    expect_stream("b2b", {4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0001, 4'b1000}, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
